mem_bus_arbiter: RTL and testbench

- Shares the single memory bus between two requesters: the instruction-fetch port (i_*) and the load/store port (d_*).
- Arbitrates round-robin, decodes the granted address into a target (VGA framebuffer, RAM, or error) through addr_translate, and runs the access on that target.
- Returns read data and an error flag with a done pulse.
- Sits between the CPU core and the VGA/RAM memories.

---
 rtl/mem_bus_arbiter_pkg.sv | 37 +++
 rtl/mem_bus_arbiter_addr_translate.sv | 29 ++
 rtl/mem_bus_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: address map, target codes,
// FSM state and bus-owner encodings.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package mem_bus_arbiter_pkg;

   // Region base addresses of the memory map
   localparam int unsigned START_ADDR = 32'd0;
   localparam int unsigned VGA_ADDR   = 32'd224000;
   localparam int unsigned RAM_ADDR   = 32'd1272576;

   // Decoded access target
   typedef enum logic [1:0] {
      TGT_NONE = 2'd0,
      TGT_RAM  = 2'd1,
      TGT_VGA  = 2'd2,
      TGT_ERR  = 2'd3
   } target_e;

   // Arbiter FSM states
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      VGA_ACC  = 3'd1,
      VGA_CAP  = 3'd2,
      RAM_WAIT = 3'd3,
      RESP     = 3'd4
   } state_e;

   // Which requester currently owns the bus
   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_bus_arbiter_addr_translate.sv
// Decodes a bus address into a target (VGA framebuffer, RAM or error) and
// the offset inside that target.
module mem_bus_arbiter_addr_translate
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = `WORD_WIDTH
) (
   input  logic [WORD_WIDTH-1:0] addr_i,
   output logic [WORD_WIDTH-1:0] offset_o,
   output target_e               target_o
);

   // Region decode: below the VGA limit is framebuffer, below the RAM limit is RAM
   always_comb begin
      offset_o = '0;
      target_o = TGT_ERR;
      if (addr_i < WORD_WIDTH'(VGA_ADDR)) begin
         target_o = TGT_VGA;
         offset_o = addr_i - WORD_WIDTH'(START_ADDR);
      end else if (addr_i < WORD_WIDTH'(RAM_ADDR)) begin
         target_o = TGT_RAM;
         offset_o = addr_i - WORD_WIDTH'(VGA_ADDR);
      end else begin
         target_o = TGT_ERR;
         offset_o = '0;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the fetch port and the
// load/store port; runs the granted access on the VGA framebuffer or RAM.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned WORD_WIDTH  = `WORD_WIDTH,
   parameter int unsigned RAM_TIMEOUT = 255,
   parameter int unsigned CNT_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic [WORD_WIDTH-1:0] i_addr,
   output logic                  i_done,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [WORD_WIDTH-1:0] d_addr,
   input  logic [WORD_WIDTH-1:0] d_wdata,
   output logic                  d_done,
   output logic [WORD_WIDTH-1:0] rdata,
   output logic                  err,
   output logic                  vga_en,
   output logic                  vga_we,
   output logic [WORD_WIDTH-1:0] vga_addr,
   output logic [WORD_WIDTH-1:0] vga_wdata,
   input  logic [WORD_WIDTH-1:0] vga_rdata,
   output logic                  ram_req,
   output logic                  ram_we,
   output logic [WORD_WIDTH-1:0] ram_addr,
   output logic [WORD_WIDTH-1:0] ram_wdata,
   input  logic                  ram_ack,
   input  logic [WORD_WIDTH-1:0] ram_rdata
);

   state_e                state_q;
   owner_e                owner_q;
   owner_e                last_grant_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [WORD_WIDTH-1:0] rdata_q;
   logic                  err_q;
   logic                  i_done_q;
   logic                  d_done_q;
   logic                  vga_en_q;
   logic                  vga_we_q;
   logic [WORD_WIDTH-1:0] vga_addr_q;
   logic [WORD_WIDTH-1:0] vga_wdata_q;
   logic                  ram_req_q;
   logic                  ram_we_q;
   logic [WORD_WIDTH-1:0] ram_addr_q;
   logic [WORD_WIDTH-1:0] ram_wdata_q;

   logic                  grant_valid_d;
   owner_e                grant_own_d;
   logic [WORD_WIDTH-1:0] grant_addr_d;
   logic                  grant_we_d;
   logic [WORD_WIDTH-1:0] grant_wdata_d;
   logic [WORD_WIDTH-1:0] grant_off_d;
   target_e               grant_tgt_d;

   // Grant selection: a lone request wins, a tie goes to the port not served last
   always_comb begin
      grant_valid_d = i_req | d_req;
      grant_own_d   = OWN_D;
      if (i_req && d_req) begin
         if (last_grant_q == OWN_D) begin
            grant_own_d = OWN_I;
         end else begin
            grant_own_d = OWN_D;
         end
      end else if (i_req) begin
         grant_own_d = OWN_I;
      end else begin
         grant_own_d = OWN_D;
      end
      if (grant_own_d == OWN_I) begin
         grant_addr_d  = i_addr;
         grant_we_d    = 1'b0;
         grant_wdata_d = '0;
      end else begin
         grant_addr_d  = d_addr;
         grant_we_d    = d_we;
         grant_wdata_d = d_wdata;
      end
   end

   mem_bus_arbiter_addr_translate #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_addr_translate (
      .addr_i   (grant_addr_d),
      .offset_o (grant_off_d),
      .target_o (grant_tgt_d)
   );

   // Arbiter FSM with all bus-facing outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= OWN_I;
         last_grant_q <= OWN_D;
         cnt_q        <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         i_done_q     <= 1'b0;
         d_done_q     <= 1'b0;
         vga_en_q     <= 1'b0;
         vga_we_q     <= 1'b0;
         vga_addr_q   <= '0;
         vga_wdata_q  <= '0;
         ram_req_q    <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
      end else begin
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_valid_d) begin
                  owner_q      <= grant_own_d;
                  last_grant_q <= grant_own_d;
                  cnt_q        <= '0;
                  rdata_q      <= '0;
                  err_q        <= 1'b0;
                  case (grant_tgt_d)
                     TGT_VGA: begin
                        state_q     <= VGA_ACC;
                        vga_en_q    <= 1'b1;
                        vga_we_q    <= grant_we_d;
                        vga_addr_q  <= grant_off_d;
                        vga_wdata_q <= grant_wdata_d;
                     end
                     TGT_RAM: begin
                        state_q     <= RAM_WAIT;
                        ram_req_q   <= 1'b1;
                        ram_we_q    <= grant_we_d;
                        ram_addr_q  <= grant_off_d;
                        ram_wdata_q <= grant_wdata_d;
                     end
                     default: begin
                        state_q  <= RESP;
                        err_q    <= 1'b1;
                        i_done_q <= (grant_own_d == OWN_I);
                        d_done_q <= (grant_own_d == OWN_D);
                     end
                  endcase
               end else begin
                  state_q <= IDLE;
               end
            end
            VGA_ACC: begin
               vga_en_q    <= 1'b0;
               vga_we_q    <= 1'b0;
               vga_addr_q  <= '0;
               vga_wdata_q <= '0;
               state_q     <= VGA_CAP;
            end
            VGA_CAP: begin
               rdata_q  <= vga_rdata;
               state_q  <= RESP;
               i_done_q <= (owner_q == OWN_I);
               d_done_q <= (owner_q == OWN_D);
            end
            RAM_WAIT: begin
               if (ram_ack || (cnt_q == CNT_WIDTH'(RAM_TIMEOUT - 32'd1))) begin
                  // An ack arriving in the timeout cycle still completes normally
                  if (ram_ack) begin
                     rdata_q <= ram_rdata;
                     err_q   <= 1'b0;
                  end else begin
                     err_q   <= 1'b1;
                  end
                  ram_req_q   <= 1'b0;
                  ram_we_q    <= 1'b0;
                  ram_addr_q  <= '0;
                  ram_wdata_q <= '0;
                  state_q     <= RESP;
                  i_done_q    <= (owner_q == OWN_I);
                  d_done_q    <= (owner_q == OWN_D);
               end else begin
                  cnt_q <= cnt_q + CNT_WIDTH'(1);
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign i_done    = i_done_q;
   assign d_done    = d_done_q;
   assign rdata     = rdata_q;
   assign err       = err_q;
   assign vga_en    = vga_en_q;
   assign vga_we    = vga_we_q;
   assign vga_addr  = vga_addr_q;
   assign vga_wdata = vga_wdata_q;
   assign ram_req   = ram_req_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, multi-cycle
// corner sequences and randomized single accesses against an address-map model.
module tb_mem_bus_arbiter;

   localparam int W   = 32;
   localparam int TMO = 255;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req;
   logic [W-1:0]  i_addr;
   logic          i_done;
   logic          d_req;
   logic          d_we;
   logic [W-1:0]  d_addr;
   logic [W-1:0]  d_wdata;
   logic          d_done;
   logic [W-1:0]  rdata;
   logic          err;
   logic          vga_en;
   logic          vga_we;
   logic [W-1:0]  vga_addr;
   logic [W-1:0]  vga_wdata;
   logic [W-1:0]  vga_rdata;
   logic          ram_req;
   logic          ram_we;
   logic [W-1:0]  ram_addr;
   logic [W-1:0]  ram_wdata;
   logic          ram_ack;
   logic [W-1:0]  ram_rdata;

   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0] bnd [6] = '{32'd0, 32'd223999, 32'd224000, 32'd1272575, 32'd1272576, 32'hFFFF_FFFF};

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .WORD_WIDTH  (W),
      .RAM_TIMEOUT (TMO),
      .CNT_WIDTH   (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_done    (i_done),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_done    (d_done),
      .rdata     (rdata),
      .err       (err),
      .vga_en    (vga_en),
      .vga_we    (vga_we),
      .vga_addr  (vga_addr),
      .vga_wdata (vga_wdata),
      .vga_rdata (vga_rdata),
      .ram_req   (ram_req),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_ack   (ram_ack),
      .ram_rdata (ram_rdata)
   );

   typedef struct {
      int          done_cyc;
      bit          done_d;
      bit          both_done;
      logic [31:0] rd;
      bit          er;
      int          vga_cnt;
      int          vga_cyc;
      logic [31:0] vaddr;
      bit          vwe;
      logic [31:0] vwdata;
      int          ram_cnt;
      int          ram_first;
      logic [31:0] raddr;
      bit          rwe;
      logic [31:0] rwdata;
      bit          overlap;
      bit          after_active;
   } obs_t;

   // tgt: 0 = VGA, 1 = RAM, 2 = ERR
   typedef struct {
      int          tgt;
      logic [31:0] off;
      bit          er;
      int          done_cyc;
      int          ram_cnt;
      logic [31:0] rd;
      bit          chk_rd;
   } exp_t;

   typedef struct {
      bit          port;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ack_delay;
      int          e_tgt;
      logic [31:0] e_off;
      bit          e_err;
      int          e_done;
   } vec_t;

   function automatic logic [31:0] vga_pat(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] ram_pat(input logic [31:0] a);
      return 32'h0000_1234 + a * 32'd3;
   endfunction

   // Reference model: expected outcome from the address map and RAM ack timing
   function automatic exp_t model(input bit port, input bit we, input logic [31:0] addr, input int ack_delay);
      exp_t e;
      bit   w;
      w = port & we;
      e = '{default: 0};
      if (addr < 32'd224000) begin
         e.tgt = 0; e.off = addr; e.er = 1'b0; e.done_cyc = 3; e.rd = vga_pat(addr);
      end else if (addr < 32'd1272576) begin
         e.tgt = 1; e.off = addr - 32'd224000;
         if (ack_delay < 0 || ack_delay >= TMO) begin
            e.er = 1'b1; e.done_cyc = TMO + 1; e.ram_cnt = TMO; e.rd = 32'd0;
         end else begin
            e.er = 1'b0; e.done_cyc = ack_delay + 2; e.ram_cnt = ack_delay + 1; e.rd = ram_pat(e.off);
         end
      end else begin
         e.tgt = 2; e.off = 32'd0; e.er = 1'b1; e.done_cyc = 1; e.rd = 32'd0;
      end
      e.chk_rd = !w && !e.er;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; ram_ack = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Drive one request and watch the target buses until done or budget expires
   task automatic do_txn(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_delay, input int budget, output obs_t o);
      o = '{default: 0};
      o.done_cyc = -1; o.vga_cyc = -1; o.ram_first = -1;
      @(negedge clk);
      if (port) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         i_req = 1'b1; i_addr = addr; d_we = 1'b1; d_wdata = $urandom;
      end
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         ram_ack = 1'b0;
         if (vga_en && ram_req) o.overlap = 1'b1;
         if (vga_en) begin
            o.vga_cnt++; o.vga_cyc = c; o.vaddr = vga_addr; o.vwe = vga_we; o.vwdata = vga_wdata;
            vga_rdata = vga_pat(vga_addr);
         end
         if (ram_req) begin
            o.ram_cnt++;
            if (o.ram_first < 0) o.ram_first = c;
            o.raddr = ram_addr; o.rwe = ram_we; o.rwdata = ram_wdata;
            if (ack_delay >= 0 && o.ram_cnt == ack_delay + 1) begin
               ram_ack = 1'b1; ram_rdata = ram_pat(ram_addr);
            end
         end
         if (i_done || d_done) begin
            o.done_cyc = c; o.done_d = d_done; o.both_done = i_done && d_done;
            o.rd = rdata; o.er = err;
            break;
         end
      end
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      o.after_active = ram_req | vga_en | i_done | d_done;
      ram_ack = 1'b0; vga_rdata = $urandom; ram_rdata = $urandom;
   endtask

   task automatic check_txn(input string tag, input bit port, input bit we, input logic [31:0] wdata,
                            input exp_t e, input obs_t o);
      bit w;
      w = port & we;
      chk({tag, ".done_cycle"}, o.done_cyc, e.done_cyc);
      chk({tag, ".done_port"}, o.done_d, port);
      chk({tag, ".both_done"}, o.both_done, 1'b0);
      chk({tag, ".err"}, o.er, e.er);
      if (e.chk_rd) chk({tag, ".rdata"}, o.rd, e.rd);
      chk({tag, ".vga_ram_overlap"}, o.overlap, 1'b0);
      chk({tag, ".idle_after"}, o.after_active, 1'b0);
      if (e.tgt == 0) begin
         chk({tag, ".vga_pulses"}, o.vga_cnt, 1);
         chk({tag, ".vga_cycle"}, o.vga_cyc, 1);
         chk({tag, ".vga_addr"}, o.vaddr, e.off);
         chk({tag, ".vga_we"}, o.vwe, w);
         if (w) chk({tag, ".vga_wdata"}, o.vwdata, wdata);
         chk({tag, ".ram_cycles"}, o.ram_cnt, 0);
      end else if (e.tgt == 1) begin
         chk({tag, ".vga_pulses"}, o.vga_cnt, 0);
         chk({tag, ".ram_first"}, o.ram_first, 1);
         chk({tag, ".ram_cycles"}, o.ram_cnt, e.ram_cnt);
         chk({tag, ".ram_addr"}, o.raddr, e.off);
         chk({tag, ".ram_we"}, o.rwe, w);
         if (w) chk({tag, ".ram_wdata"}, o.rwdata, wdata);
      end else begin
         chk({tag, ".vga_pulses"}, o.vga_cnt, 0);
         chk({tag, ".ram_cycles"}, o.ram_cnt, 0);
      end
   endtask

   initial begin
      vec_t        tbl [10];
      obs_t        o;
      exp_t        e;
      int          seen, guard, bad, ndone, rc, exp_last, exp_port;
      bit          ire, dre, port, we;
      logic [31:0] addr, wdata, last_raddr;
      int          ack;

      i_addr = '0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      vga_rdata = '0; ram_rdata = '0;
      do_reset();

      // Reset state: every output low
      @(negedge clk);
      chk("reset.i_done", i_done, 1'b0);
      chk("reset.d_done", d_done, 1'b0);
      chk("reset.err", err, 1'b0);
      chk("reset.rdata", rdata, 32'd0);
      chk("reset.vga_en", vga_en, 1'b0);
      chk("reset.ram_req", ram_req, 1'b0);
      chk("reset.ram_addr", ram_addr, 32'd0);

      // Directed table: port(1=D), we, addr, wdata, ack_delay(-1 never), tgt, offset, err, done cycle
      tbl[0] = '{1'b1, 1'b1, 32'd100,     32'h0000_ABCD,  0, 0, 32'd100,     1'b0,   3};
      tbl[1] = '{1'b0, 1'b0, 32'd224000,  32'd0,          3, 1, 32'd0,       1'b0,   5};
      tbl[2] = '{1'b1, 1'b0, 32'd1272576, 32'd0,          0, 2, 32'd0,       1'b1,   1};
      tbl[3] = '{1'b1, 1'b0, 32'd1272575, 32'd0,          0, 1, 32'd1048575, 1'b0,   2};
      tbl[4] = '{1'b1, 1'b0, 32'd223999,  32'd0,          0, 0, 32'd223999,  1'b0,   3};
      tbl[5] = '{1'b1, 1'b0, 32'd300000,  32'd0,         -1, 1, 32'd76000,   1'b1, 256};
      tbl[6] = '{1'b0, 1'b0, 32'd500000,  32'd0,        254, 1, 32'd276000,  1'b0, 256};
      tbl[7] = '{1'b1, 1'b1, 32'd1272576, 32'h1111_2222,  0, 2, 32'd0,       1'b1,   1};
      tbl[8] = '{1'b1, 1'b1, 32'd700000,  32'h0000_55AA,  1, 1, 32'd476000,  1'b0,   3};
      tbl[9] = '{1'b0, 1'b0, 32'd0,       32'd0,          0, 0, 32'd0,       1'b0,   3};

      for (int i = 0; i < 10; i++) begin
         e = '{default: 0};
         e.tgt = tbl[i].e_tgt; e.off = tbl[i].e_off; e.er = tbl[i].e_err; e.done_cyc = tbl[i].e_done;
         e.rd = (e.tgt == 0) ? vga_pat(e.off) : ((e.tgt == 1) ? ram_pat(e.off) : 32'd0);
         e.ram_cnt = (e.tgt != 1) ? 0 : (e.er ? TMO : tbl[i].ack_delay + 1);
         e.chk_rd = !(tbl[i].port & tbl[i].we) && !e.er;
         do_txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].ack_delay, e.done_cyc + 10, o);
         check_txn($sformatf("vec%0d", i), tbl[i].port, tbl[i].we, tbl[i].wdata, e, o);
      end
      chk("vec1.rdata_1234", ram_pat(32'd0), 32'h0000_1234);

      // Round-robin: both ports held from reset, grants must alternate I, D, I, D
      do_reset();
      @(negedge clk);
      i_addr = 32'd224016; d_addr = 32'd224032; d_we = 1'b0; d_wdata = '0;
      i_req = 1'b1; d_req = 1'b1;
      exp_last = 1; ndone = 0; rc = 0; ire = 1'b0; dre = 1'b0; last_raddr = '0;
      for (int c = 0; c < 400 && ndone < 6; c++) begin
         @(negedge clk);
         ram_ack = 1'b0;
         if (ire) begin i_req = 1'b1; ire = 1'b0; end
         if (dre) begin d_req = 1'b1; dre = 1'b0; end
         if (ram_req) begin
            rc++;
            if (rc == 2) begin
               ram_ack = 1'b1; ram_rdata = ram_pat(ram_addr); last_raddr = ram_addr; rc = 0;
            end
         end
         if (i_done || d_done) begin
            exp_port = (exp_last == 1) ? 0 : 1;
            chk($sformatf("arb%0d.owner", ndone), d_done, exp_port);
            chk($sformatf("arb%0d.ram_addr", ndone), last_raddr, (exp_port == 1) ? 32'd32 : 32'd16);
            chk($sformatf("arb%0d.rdata", ndone), rdata, ram_pat((exp_port == 1) ? 32'd32 : 32'd16));
            exp_last = exp_port; ndone++;
            if (i_done) begin i_req = 1'b0; ire = 1'b1; end
            if (d_done) begin d_req = 1'b0; dre = 1'b1; end
         end
      end
      i_req = 1'b0; d_req = 1'b0; ram_ack = 1'b0;
      chk("arb.completions", ndone, 6);
      repeat (3) @(negedge clk);

      // Reset in the middle of a RAM wait: request drops, no completion
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd400000;
      seen = 0; guard = 0;
      while (seen < 3 && guard < 20) begin
         @(negedge clk);
         guard++;
         if (ram_req) seen++;
      end
      chk("rstmid.ram_req_seen", seen, 3);
      rst = 1'b1; d_req = 1'b0;
      @(negedge clk);
      chk("rstmid.ram_req", ram_req, 1'b0);
      chk("rstmid.no_done", i_done | d_done, 1'b0);
      rst = 1'b0;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (i_done || d_done || ram_req || vga_en) bad++;
      end
      chk("rstmid.quiet", bad, 0);
      e = model(1'b0, 1'b0, 32'd230000, 2);
      do_txn(1'b0, 1'b0, 32'd230000, 32'd0, 2, e.done_cyc + 10, o);
      check_txn("rstmid.after", 1'b0, 1'b0, 32'd0, e, o);

      // Randomized single accesses against the address-map model
      for (int n = 0; n < 30; n++) begin
         port = 1'($urandom_range(0, 1));
         we   = port ? 1'($urandom_range(0, 1)) : 1'b0;
         case ($urandom_range(0, 3))
            0:       addr = $urandom_range(0, 223999);
            1:       addr = $urandom_range(224000, 1272575);
            2:       addr = $urandom_range(1272576, 32'h00FF_FFFF);
            default: addr = bnd[$urandom_range(0, 5)];
         endcase
         ack   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
         wdata = $urandom;
         e = model(port, we, addr, ack);
         do_txn(port, we, addr, wdata, ack, e.done_cyc + 10, o);
         check_txn($sformatf("rnd%0d", n), port, we, wdata, e, o);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
